// File: rtl/uart_arb_pkg.sv
// Shared types for the two-requester UART transmit arbiter:
// FSM state enum, requester count and byte width.
package uart_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int BYTE_W  = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_START,
        ARB_WAIT_BUSY,
        ARB_WAIT_DONE
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Byte stream from one requester to the arbiter.
// Ports: valid/data/last (requester -> arbiter), ready (arbiter -> requester).
interface uart_tx_arb_if;
    import uart_arb_pkg::*;

    logic  valid;
    byte_t data;
    logic  last;
    logic  ready;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);

endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding bytes from two requesters into async_send,
// with frame locking and a launch timeout.
// Ports: clk, rst_n, req0/req1 (slave streams), TxD_busy in,
//        Tx_start, TxD_data, grant_id, tx_err out.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int BUSY_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_tx_arb_if.slave req0,
    uart_tx_arb_if.slave req1,
    input  logic        TxD_busy,
    output logic        Tx_start,
    output byte_t       TxD_data,
    output logic        grant_id,
    output logic        tx_err
);

    localparam logic [1:0] S_IDLE      = 2'(ARB_IDLE);
    localparam logic [1:0] S_START     = 2'(ARB_START);
    localparam logic [1:0] S_WAIT_BUSY = 2'(ARB_WAIT_BUSY);
    localparam logic [1:0] S_WAIT_DONE = 2'(ARB_WAIT_DONE);

    localparam int CW = $clog2(BUSY_WAIT + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    byte_t         data_q, data_d;
    logic          grant_q, grant_d;
    logic          lock_q, lock_d;
    logic          lock_id_q, lock_id_d;

    logic          sel_vld;
    logic          sel_id;
    byte_t         sel_data;
    logic          sel_last;
    logic          can_acc;
    logic          xfer;
    logic          timeout;
    logic [NUM_REQ-1:0] rdy;

    // While a frame is locked only its owner may be picked; otherwise a
    // tie goes to the requester that did not win last time.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 1'b0;
        if (lock_q) begin
            sel_id  = lock_id_q;
            sel_vld = lock_id_q ? req1.valid : req0.valid;
        end else if (req0.valid && req1.valid) begin
            sel_vld = 1'b1;
            sel_id  = ~grant_q;
        end else if (req0.valid) begin
            sel_vld = 1'b1;
        end else if (req1.valid) begin
            sel_vld = 1'b1;
            sel_id  = 1'b1;
        end
    end

    assign sel_data = sel_id ? req1.data : req0.data;
    assign sel_last = sel_id ? req1.last : req0.last;

    assign can_acc = (state_q == S_IDLE) && !TxD_busy;
    assign xfer    = can_acc && sel_vld;

    assign rdy[0]     = xfer && !sel_id;
    assign rdy[1]     = xfer && sel_id;
    assign req0.ready = rdy[0];
    assign req1.ready = rdy[1];

    // Counter holds cycles already spent in WAIT_BUSY with busy low.
    assign timeout = (cnt_q == CW'(BUSY_WAIT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        grant_d   = grant_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    data_d    = sel_data;
                    grant_d   = sel_id;
                    lock_d    = !sel_last;
                    lock_id_d = sel_id;
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (TxD_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timeout) begin
                    // Launch failed: abandon the rest of the frame.
                    state_d = S_IDLE;
                    lock_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!TxD_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            grant_q   <= 1'b1;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    assign Tx_start = (state_q == S_START);
    assign TxD_data = data_q;
    assign grant_id = grant_q;
    assign tx_err   = (state_q == S_WAIT_BUSY) && !TxD_busy && timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed scenarios then random
// frames from both requesters against a rule-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_arb;

    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arb_if r0 ();
    uart_tx_arb_if r1 ();

    logic       busy_m = 1'b0;
    logic       busy_hold = 1'b0;
    logic       txd_busy;
    logic       tx_start;
    logic [7:0] txd;
    logic       grant;
    logic       tx_err;

    assign txd_busy = busy_m | busy_hold;

    uart_tx_arb #(.BUSY_WAIT(BW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (r0),
        .req1     (r1),
        .TxD_busy (txd_busy),
        .Tx_start (tx_start),
        .TxD_data (txd),
        .grant_id (grant),
        .tx_err   (tx_err)
    );

    // stimulus knobs
    int fail_pct = 0;
    int dly_max = 0;
    int len_min = 10;
    int len_max = 10;
    int gap_max = 0;
    bit flush = 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err = 0;

    logic [8:0] rq [2][$];      // {last, data} per requester
    logic [7:0] tx_log [$];

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t expq [$];
    int   errq [$];

    task automatic chk(input bit ok, input string name,
                       input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // requesters: present queued bytes, hold until accepted
    for (genvar g = 0; g < 2; g++) begin : g_req
        logic       v = 1'b0;
        logic [7:0] d = 8'h00;
        logic       l = 1'b0;
        initial begin
            int gap;
            bit took;
            gap = 0;
            forever begin
                @(negedge clk);
                took = v && rst_n && ((g == 0) ? r0.ready : r1.ready);
                @(posedge clk);
                #1;
                if (flush) begin
                    v = 1'b0;
                    rq[g].delete();
                    gap = 0;
                end else begin
                    if (took) begin
                        void'(rq[g].pop_front());
                        v = 1'b0;
                        gap = l ? int'($urandom_range(gap_max)) : 0;
                    end
                    if (!v) begin
                        if (gap > 0) gap--;
                        else if (rq[g].size() > 0) begin
                            v = 1'b1;
                            {l, d} = rq[g][0];
                        end
                    end
                end
            end
        end
    end

    assign r0.valid = g_req[0].v;
    assign r0.data  = g_req[0].d;
    assign r0.last  = g_req[0].l;
    assign r1.valid = g_req[1].v;
    assign r1.data  = g_req[1].d;
    assign r1.last  = g_req[1].l;

    // async_send model: busy rises dly cycles after the launch, or never
    initial begin
        int dly;
        int len;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                if (int'($urandom_range(99)) < fail_pct) begin
                    errq.push_back(cyc + BW);
                end else begin
                    dly = $urandom_range(dly_max);
                    len = $urandom_range(len_max, len_min);
                    repeat (dly + 1) @(posedge clk);
                    #1 busy_m = 1'b1;
                    repeat (len) @(posedge clk);
                    #1 busy_m = 1'b0;
                end
            end
        end
    end

    // monitor / reference model
    logic       own_v;
    logic       own_id;
    logic       last_w;
    bit         in_flight;
    bit         seen_busy;
    bit         acc_prev;
    logic [7:0] prev_data;

    initial begin
        logic rd0, rd1, w;
        bit   w_ok, clr;
        exp_t e;
        int   ec;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                own_v = 1'b0;
                own_id = 1'b0;
                last_w = 1'b1;
                in_flight = 1'b0;
                seen_busy = 1'b0;
                acc_prev = 1'b0;
                prev_data = 8'h00;
                expq.delete();
                errq.delete();
            end else begin
                rd0 = r0.ready;
                rd1 = r1.ready;
                if (rd0 || rd1) begin
                    chk(!(rd0 && rd1), "one_ready", int'({rd0, rd1}), 1);
                    chk(!in_flight && !txd_busy, "ready_when_idle",
                        int'({in_flight, txd_busy}), 0);
                end
                if (txd != prev_data)
                    chk(acc_prev, "data_hold", txd, prev_data);
                prev_data = txd;
                acc_prev = 1'b0;
                if (tx_start) begin
                    if (expq.size() == 0) begin
                        chk(1'b0, "spurious_start", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk(txd == e.data, "tx_data", txd, e.data);
                        chk(grant == e.id, "grant_id", grant, e.id);
                        chk(cyc == e.cyc + 1, "start_latency", cyc - e.cyc, 1);
                    end
                    tx_log.push_back(txd);
                end
                if (tx_err) begin
                    if (errq.size() == 0) begin
                        chk(1'b0, "spurious_err", cyc, 0);
                    end else begin
                        ec = errq.pop_front();
                        chk(cyc == ec, "err_cycle", cyc, ec);
                    end
                    own_v = 1'b0;
                    n_err++;
                end
                clr = in_flight && (tx_err || (seen_busy && !txd_busy));
                if (in_flight && txd_busy) seen_busy = 1'b1;
                if (clr) in_flight = 1'b0;
                w_ok = 1'b0;
                w = 1'b0;
                if (r0.valid && rd0) begin
                    w_ok = 1'b1;
                end else if (r1.valid && rd1) begin
                    w_ok = 1'b1;
                    w = 1'b1;
                end
                if (w_ok) begin
                    if (own_v)
                        chk(w == own_id, "lock_owner", w, own_id);
                    else if (r0.valid && r1.valid)
                        chk(w != last_w, "round_robin", w, !last_w);
                    last_w = w;
                    own_id = w;
                    own_v = !(w ? r1.last : r0.last);
                    expq.push_back('{id: w, data: (w ? r1.data : r0.data),
                                     cyc: cyc});
                    in_flight = 1'b1;
                    seen_busy = 1'b0;
                    acc_prev = 1'b1;
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !(rq[0].size() == 0 && rq[1].size() == 0 &&
               !g_req[0].v && !g_req[1].v && expq.size() == 0 &&
               !in_flight)) begin
            @(negedge clk);
            n++;
        end
        chk(n < budget, "drain_timeout", n, budget);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_log(input int base, input logic [31:0] seq,
                           input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = seq[8*(n-1-i) +: 8];
            if (tx_log.size() > base + i)
                chk(tx_log[base + i] == b, "tx_order", tx_log[base + i], b);
            else
                chk(1'b0, "tx_order_missing", i, b);
        end
    endtask

    initial begin
        int base;
        int e0;
        int n;
        int total;

        // reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk(tx_start == 1'b0, "rst_tx_start", tx_start, 0);
        chk(txd == 8'h00, "rst_txd", txd, 0);
        chk(grant == 1'b1, "rst_grant", grant, 1);
        chk(tx_err == 1'b0, "rst_tx_err", tx_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // alternating single-byte frames
        len_min = 1;
        len_max = 3;
        base = tx_log.size();
        rq[0].push_back(9'h1A1);
        rq[0].push_back(9'h1A1);
        rq[1].push_back(9'h1B2);
        rq[1].push_back(9'h1B2);
        wait_idle(400);
        chk_log(base, 32'hA1B2A1B2, 4);

        // locked frame on req0 holds off req1
        base = tx_log.size();
        rq[0].push_back(9'h010);
        rq[0].push_back(9'h011);
        rq[0].push_back(9'h112);
        rq[1].push_back(9'h120);
        wait_idle(400);
        chk_log(base, 32'h10111220, 4);

        // basic single byte, busy 10 cycles
        len_min = 10;
        len_max = 10;
        base = tx_log.size();
        rq[0].push_back(9'h13A);
        wait_idle(400);
        chk_log(base, 32'h0000003A, 1);
        chk(grant == 1'b0, "grant_after_3A", grant, 0);
        chk(txd == 8'h3A, "txd_after_3A", txd, 8'h3A);

        // launch failure mid-frame releases the lock
        fail_pct = 100;
        e0 = n_err;
        rq[0].push_back(9'h040);
        n = 0;
        while (n_err == e0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(n_err == e0 + 1, "err_seen", n_err - e0, 1);
        fail_pct = 0;
        base = tx_log.size();
        rq[1].push_back(9'h150);
        wait_idle(400);
        chk_log(base, 32'h00000050, 1);

        // busy high out of reset blocks acceptance
        busy_hold = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rq[0].push_back(9'h155);
        repeat (5) begin
            @(negedge clk);
            chk(r0.ready == 1'b0, "ready_while_busy", r0.ready, 0);
        end
        @(posedge clk);
        #1 busy_hold = 1'b0;
        @(negedge clk);
        chk(r0.ready == 1'b1, "ready_after_busy", r0.ready, 1);
        wait_idle(400);

        // reset while req1 owns a frame and the byte is in flight
        len_min = 20;
        len_max = 20;
        rq[1].push_back(9'h061);
        rq[1].push_back(9'h162);
        n = 0;
        while (!busy_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(busy_m, "busy_before_reset", n, 40);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(tx_start == 1'b0, "mid_rst_tx_start", tx_start, 0);
        chk(txd == 8'h00, "mid_rst_txd", txd, 0);
        chk(grant == 1'b1, "mid_rst_grant", grant, 1);
        chk(tx_err == 1'b0, "mid_rst_tx_err", tx_err, 0);
        chk(!r0.ready && !r1.ready, "mid_rst_ready",
            int'({r0.ready, r1.ready}), 0);
        flush = 1'b1;
        repeat (2) @(posedge clk);
        #1 flush = 1'b0;
        n = 0;
        while (busy_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        len_min = 1;
        len_max = 3;
        base = tx_log.size();
        rq[0].push_back(9'h170);
        rq[1].push_back(9'h171);
        wait_idle(400);
        chk_log(base, 32'h00007071, 2);

        // random frames from both sides
        gap_max = 3;
        dly_max = BW - 1;
        len_min = 1;
        len_max = 6;
        fail_pct = 15;
        total = 0;
        base = tx_log.size();
        for (int r = 0; r < 2; r++) begin
            for (int f = 0; f < 25; f++) begin
                n = $urandom_range(3, 1);
                for (int b = 0; b < n; b++) begin
                    rq[r].push_back({b == n - 1, 8'($urandom)});
                    total++;
                end
            end
        end
        wait_idle(20000);
        chk(tx_log.size() - base == total, "random_count",
            tx_log.size() - base, total);
        chk(errq.size() == 0, "err_pending", errq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
